// File: rtl/rc5_key_expand.sv
// RC5-32 key-schedule engine: expands a KEY_WORDS x 32-bit user key into the
// 2*ROUNDS+2 round subkeys, one INIT entry or one MIX step per clock.
//
// Handshake: key_vld is level-sampled and is accepted only in IDLE or DONE.
// Acceptance captures ukey, drops key_rdy and raises busy on the same edge.
// A request made while busy=1 is dropped; nothing is queued and nothing
// restarts. key_rdy=1 means skey holds a complete table, and skey stays
// stable until the next accepted request. busy and key_rdy are never both 1.
module rc5_key_expand #(
  parameter int ROUNDS    = 12,
  parameter int KEY_WORDS = 4
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic [32*KEY_WORDS-1:0]     ukey,
  input  logic                        key_vld,
  output logic                        busy,
  output logic                        key_rdy,
  output logic [32*(2*ROUNDS+2)-1:0]  skey
);

  localparam int T  = 2*ROUNDS + 2;
  localparam int C  = KEY_WORDS;
  localparam int N  = 3 * ((T > C) ? T : C);
  localparam int IW = (T > 1) ? $clog2(T) : 1;
  localparam int JW = (C > 1) ? $clog2(C) : 1;
  localparam int SW = $clog2(N + 1);

  localparam logic [31:0] P32 = 32'hB7E1_5163;
  localparam logic [31:0] Q32 = 32'h9E37_79B9;

  typedef enum logic [1:0] {IDLE, INIT, MIX, DONE} state_t;

  state_t          state_q, state_d;
  logic [32*T-1:0] s_q, s_d;
  logic [32*C-1:0] l_q, l_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [IW-1:0]   i_q, i_d;
  logic [JW-1:0]   j_q, j_d;
  logic [SW-1:0]   step_q, step_d;
  logic            busy_q, busy_d;
  logic            key_rdy_q, key_rdy_d;

  logic [IW-1:0]   i_prev;
  logic [31:0]     s_prev;
  logic [31:0]     a_new;
  logic [31:0]     b_new;
  logic [4:0]      b_amt;

  // Rotate left by the low 5 bits; an amount of 0 returns x unchanged
  // because a 32-bit value shifted right by 32 is zero.
  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] amt);
    return (x << amt) | (x >> (6'd32 - {1'b0, amt}));
  endfunction

  // One mixing step and the INIT predecessor lookup, both purely combinational.
  always_comb begin
    i_prev = (i_q == '0) ? IW'(T - 1) : i_q - IW'(1);
    s_prev = s_q[32*i_prev +: 32];
    a_new  = rotl(s_q[32*i_q +: 32] + a_q + b_q, 5'd3);
    // Only the low 5 bits of A'+B matter, so add just those.
    b_amt  = a_new[4:0] + b_q[4:0];
    b_new  = rotl(l_q[32*j_q +: 32] + a_new + b_q, b_amt);
  end

  // Next-state and datapath update for the IDLE/INIT/MIX/DONE sequencer.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    l_d       = l_q;
    a_d       = a_q;
    b_d       = b_q;
    i_d       = i_q;
    j_d       = j_q;
    step_d    = step_q;
    busy_d    = busy_q;
    key_rdy_d = key_rdy_q;
    case (state_q)
      IDLE, DONE: begin
        if (key_vld) begin
          l_d       = ukey;
          a_d       = '0;
          b_d       = '0;
          i_d       = '0;
          j_d       = '0;
          step_d    = '0;
          key_rdy_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = INIT;
        end
      end
      INIT: begin
        s_d[32*i_q +: 32] = (i_q == '0) ? P32 : s_prev + Q32;
        if (i_q == IW'(T - 1)) begin
          i_d     = '0;
          state_d = MIX;
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      MIX: begin
        s_d[32*i_q +: 32] = a_new;
        l_d[32*j_q +: 32] = b_new;
        a_d    = a_new;
        b_d    = b_new;
        i_d    = (i_q == IW'(T - 1)) ? '0 : i_q + IW'(1);
        j_d    = (j_q == JW'(C - 1)) ? '0 : j_q + JW'(1);
        step_d = step_q + SW'(1);
        if (step_q == SW'(N - 1)) begin
          // The working copy of the user key is not kept once the table is done.
          l_d       = '0;
          busy_d    = 1'b0;
          key_rdy_d = 1'b1;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; clr aborts any expansion and clears the table.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= IDLE;
      s_q       <= '0;
      l_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      step_q    <= '0;
      busy_q    <= 1'b0;
      key_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      l_q       <= l_d;
      a_q       <= a_d;
      b_q       <= b_d;
      i_q       <= i_d;
      j_q       <= j_d;
      step_q    <= step_d;
      busy_q    <= busy_d;
      key_rdy_q <= key_rdy_d;
    end
  end

  assign busy    = busy_q;
  assign key_rdy = key_rdy_q;
  assign skey    = s_q;

endmodule
